uart_apb_regif: RTL and testbench
=================================

// Module: uart_apb_regif
// PURPOSE
//  APB3 responder giving a CPU register access to the UART core: pushes TX bytes, pops RX bytes,
//  programs line control, reports sticky errors, raises an interrupt. Sits between the
//  system APB bus and the UART core's wr_en/wdata/rdata/config/error pins.
// PARAMETERS
//  ADDR_W   4    APB address width; decode uses paddr[3:2], paddr[1:0] ignored
//  DATA_W   32   APB data width; only [7:0] meaningful, upper bits read 0
// PORTS
//  clk          in   1       single clock
//  rst          in   1       synchronous, active-high reset
//  psel         in   1       APB select
//  penable      in   1       APB enable (access phase)
//  pwrite       in   1       1=write, 0=read
//  paddr        in   ADDR_W  byte address
//  pwdata       in   DATA_W  write data
//  prdata       out  DATA_W  read data, valid while pready=1
//  pready       out  1       transfer completion
//  pslverr      out  1       error response, valid while pready=1
//  tx_full      in   1       core TX FIFO full
//  tx_wr_en     out  1       one-cycle push strobe to core TX FIFO
//  tx_wdata     out  8       TX byte, valid with tx_wr_en
//  rx_valid     in   1       one-cycle strobe: new received byte on rx_data
//  rx_data      in   8       received byte
//  rx_parity_err in  1       parity error of byte, sampled with rx_valid
//  rx_frame_err in   1       frame error of byte, sampled with rx_valid
//  bclk_mode    out  1       LCR[0]: 0=x16, 1=x13 sampling
//  tlen         out  2       LCR[2:1]: 00=5b 01=6b 10=7b 11=8b
//  parity_en    out  1       LCR[3]
//  parity_type  out  1       LCR[4]: 0=even, 1=odd
//  irq          out  1       level interrupt, registered
// BEHAVIOUR
//  Register map (paddr[3:2]): 0 DATA (W push TX / R pop RX), 1 LCR (RW, reset 0x06),
//   2 STATUS (R; W1C bits[4:2]): [0]rx_avail [1]tx_full [2]overrun [3]parity_err [4]frame_err,
//   3 IER (RW, reset 0): [0]rx_ie [1]err_ie.
//  APB FSM IDLE->SETUP(psel&!penable)->WAIT(psel&penable)->DONE(pready=1, 1 cycle)->IDLE.
//   Exactly one wait state: pready rises 2nd cycle of access phase; 3 cycles per transfer min.
//   Register side effects commit in the DONE cycle only. psel drop before DONE -> IDLE, no effect.
//  prdata/pslverr registered, 0 outside DONE. Reset: FSM IDLE, all outputs 0, LCR 0x06,
//   rx holding reg 0, all status flags 0, irq 0.
//  DATA write: tx_full=0 in DONE -> tx_wr_en=1 for that cycle, tx_wdata=pwdata[7:0];
//   tx_full=1 -> no push, pslverr=1. DATA read: prdata=holding byte; clears rx_avail;
//   read with rx_avail=0 returns last byte, pslverr=0.
//  RX capture: rx_valid & !rx_avail -> load byte, rx_avail=1, OR error inputs into sticky bits.
//   rx_valid & rx_avail -> byte dropped, overrun=1, errors of dropped byte not recorded.
//   rx_valid in same cycle as DATA-read DONE -> read returns old byte, new byte loaded,
//   rx_avail stays 1, no overrun.
//  STATUS W1C: write 1 clears bit; rx_valid setting same bit in same cycle wins (set).
//  LCR writes take effect next cycle regardless of traffic; core owns mid-frame consequences.
//  irq = (rx_ie & rx_avail) | (err_ie & (overrun|parity_err|frame_err)), registered 1 cycle.
//  Reset mid-transfer: FSM to IDLE, no side effect, pready never asserted for that transfer.
// STRUCTURE
//  uart_pkg: register offsets, STATUS/LCR/IER bit indices, LCR_RST=8'h06, APB state enum.
//  Single module; no sub-module (FSM + ~20 flops of register state).
// TESTING
//  Reset -> read LCR=0x06, STATUS=0, IER=0; each transfer pready exactly 1 cycle, 3rd cycle.
//  tx_full=0, write DATA 0xA5 -> single tx_wr_en pulse with tx_wdata=0xA5; tx_full=1 -> pslverr=1, no pulse.
//  rx_valid 0x3C, then 0x7E before read -> DATA reads 0x3C, STATUS=0x05 (avail,overrun); W1C 0x04 -> 0x00.
//  rx_valid with rx_parity_err=1, IER=0x2 -> irq=1 next cycle; STATUS W1C 0x08 -> irq=0.
//  rx_valid coincident with DATA-read DONE -> prdata old byte, rx_avail=1, overrun=0.
//  Write LCR 0x1B -> tlen=01, bclk_mode=1, parity_en=1, parity_type=1; paddr/illegal none (all decoded).

Source files
------------

// File: rtl/uart_apb_regif_pkg.sv
// Shared constants for the UART APB register interface: register offsets,
// register bit positions, reset values and APB handshake states.
package uart_apb_regif_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_LCR    = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_IER    = 2'd3;

    localparam int STS_RX_AVAIL   = 0;
    localparam int STS_TX_FULL    = 1;
    localparam int STS_OVERRUN    = 2;
    localparam int STS_PARITY_ERR = 3;
    localparam int STS_FRAME_ERR  = 4;

    localparam int LCR_BCLK_MODE   = 0;
    localparam int LCR_TLEN_LO     = 1;
    localparam int LCR_PARITY_EN   = 3;
    localparam int LCR_PARITY_TYPE = 4;

    localparam int IER_RX_IE  = 0;
    localparam int IER_ERR_IE = 1;

    localparam logic [7:0] LCR_RST = 8'h06;

    // The setup phase is recognised while in ST_IDLE; ST_WAIT is the single
    // wait state (first access cycle) and ST_DONE the cycle with pready high.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/uart_apb_regif.sv
// APB3 responder exposing the UART core's TX push, RX pop, line control,
// sticky error status and interrupt enables as four word registers.
module uart_apb_regif
    import uart_apb_regif_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    input  logic              tx_full,
    output logic              tx_wr_en,
    output logic [7:0]        tx_wdata,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              rx_parity_err,
    input  logic              rx_frame_err,
    output logic              bclk_mode,
    output logic [1:0]        tlen,
    output logic              parity_en,
    output logic              parity_type,
    output logic              irq
);

    logic [1:0] state;
    logic [7:0] lcr;
    logic [1:0] ier;
    logic [7:0] rx_hold;
    logic       rx_avail;
    logic       overrun;
    logic       parity_err;
    logic       frame_err;

    logic [1:0] reg_sel;
    logic       enter_done;
    logic       in_done;
    logic       rd_pop;
    logic       sts_w1c;
    logic [2:0] w1c_mask;
    logic       rx_capture;
    logic       rx_overrun;
    logic [7:0] rd_val;
    logic       unused_bits;

    assign reg_sel     = paddr[3:2];
    assign unused_bits = ^{paddr, pwdata};
    assign enter_done  = (state == ST_WAIT) && psel && penable;
    assign in_done     = (state == ST_DONE);
    assign pready      = in_done;

    assign rd_pop   = in_done && !pwrite && (reg_sel == REG_DATA);
    assign sts_w1c  = in_done && pwrite && (reg_sel == REG_STATUS);
    assign w1c_mask = sts_w1c ? pwdata[STS_FRAME_ERR:STS_OVERRUN] : 3'b000;

    // A pop in the same cycle frees the holding register, so the new byte
    // lands without an overrun.
    assign rx_capture = rx_valid && (!rx_avail || rd_pop);
    assign rx_overrun = rx_valid && rx_avail && !rd_pop;

    always_comb begin
        rd_val = 8'h00;
        case (reg_sel)
            REG_DATA:   rd_val = rx_hold;
            REG_LCR:    rd_val = lcr;
            REG_STATUS: rd_val = {3'b000, frame_err, parity_err, overrun, tx_full, rx_avail};
            REG_IER:    rd_val = {6'b000000, ier};
            default:    rd_val = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            prdata     <= '0;
            pslverr    <= 1'b0;
            tx_wr_en   <= 1'b0;
            tx_wdata   <= 8'h00;
            lcr        <= LCR_RST;
            ier        <= 2'b00;
            rx_hold    <= 8'h00;
            rx_avail   <= 1'b0;
            overrun    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            irq        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: state <= (psel && !penable) ? ST_WAIT : ST_IDLE;
                ST_WAIT: state <= (psel && penable) ? ST_DONE : ST_IDLE;
                default: state <= ST_IDLE;
            endcase

            // Response and TX push are registered so they line up with pready.
            prdata   <= (enter_done && !pwrite) ? DATA_W'(rd_val) : '0;
            pslverr  <= enter_done && pwrite && (reg_sel == REG_DATA) && tx_full;
            tx_wr_en <= enter_done && pwrite && (reg_sel == REG_DATA) && !tx_full;
            if (enter_done && pwrite && (reg_sel == REG_DATA) && !tx_full)
                tx_wdata <= pwdata[7:0];

            if (in_done && pwrite && (reg_sel == REG_LCR)) lcr <= pwdata[7:0];
            if (in_done && pwrite && (reg_sel == REG_IER)) ier <= pwdata[1:0];

            if (rx_capture) begin
                rx_hold  <= rx_data;
                rx_avail <= 1'b1;
            end else if (rd_pop) begin
                rx_avail <= 1'b0;
            end

            overrun    <= (overrun    && !w1c_mask[0]) || rx_overrun;
            parity_err <= (parity_err && !w1c_mask[1]) || (rx_capture && rx_parity_err);
            frame_err  <= (frame_err  && !w1c_mask[2]) || (rx_capture && rx_frame_err);

            irq <= (ier[IER_RX_IE] && rx_avail) ||
                   (ier[IER_ERR_IE] && (overrun || parity_err || frame_err));
        end
    end

    assign bclk_mode   = lcr[LCR_BCLK_MODE];
    assign tlen        = lcr[LCR_TLEN_LO +: 2];
    assign parity_en   = lcr[LCR_PARITY_EN];
    assign parity_type = lcr[LCR_PARITY_TYPE];

endmodule

// File: tb/tb_uart_apb_regif.sv
// Directed plus randomized bench for uart_apb_regif against a register-level
// model of the UART programming interface.
module tb_uart_apb_regif;

    logic        clk = 1'b0;
    logic        rst;
    logic        psel, penable, pwrite;
    logic [3:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic        tx_full;
    logic        tx_wr_en;
    logic [7:0]  tx_wdata;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_parity_err, rx_frame_err;
    logic        bclk_mode;
    logic [1:0]  tlen;
    logic        parity_en, parity_type;
    logic        irq;

    int checks = 0;
    int errors = 0;

    // Reference model: programmer-visible register contents.
    logic [7:0] m_lcr;
    logic [1:0] m_ier;
    logic [7:0] m_hold;
    logic       m_avail, m_ovr, m_pe, m_fe;

    uart_apb_regif #(.ADDR_W(4), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .tx_full(tx_full), .tx_wr_en(tx_wr_en), .tx_wdata(tx_wdata),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_parity_err(rx_parity_err),
        .rx_frame_err(rx_frame_err), .bclk_mode(bclk_mode), .tlen(tlen),
        .parity_en(parity_en), .parity_type(parity_type), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic m_irq();
        return (m_ier[0] & m_avail) | (m_ier[1] & (m_ovr | m_pe | m_fe));
    endfunction

    task automatic model_reset();
        m_lcr = 8'h06; m_ier = 2'b00; m_hold = 8'h00;
        m_avail = 1'b0; m_ovr = 1'b0; m_pe = 1'b0; m_fe = 1'b0;
    endtask

    task automatic model_rx(input logic [7:0] b, input logic p, input logic f);
        if (!m_avail) begin
            m_hold = b; m_avail = 1'b1; m_pe |= p; m_fe |= f;
        end else begin
            m_ovr = 1'b1;
        end
    endtask

    task automatic chk_lcr_pins();
        chk("bclk_mode", bclk_mode, m_lcr[0]);
        chk("tlen", tlen, m_lcr[2:1]);
        chk("parity_en", parity_en, m_lcr[3]);
        chk("parity_type", parity_type, m_lcr[4]);
    endtask

    // One APB transfer: setup, wait state, DONE, then two idle cycles.
    task automatic apb(input logic wr, input logic [1:0] rs, input logic [31:0] wd,
                       input logic full, input logic rxd, input logic [7:0] rxb,
                       output logic [31:0] rd, output logic err,
                       output logic push, output logic [7:0] pb);
        chk("pready_before", pready, 1'b0);
        psel = 1'b1; penable = 1'b0; pwrite = wr;
        paddr = {rs, 2'($urandom)}; pwdata = wd; tx_full = full;
        @(posedge clk); #1;
        chk("pready_wait", pready, 1'b0);
        chk("push_wait", tx_wr_en, 1'b0);
        penable = 1'b1;
        @(posedge clk); #1;
        chk("pready_done", pready, 1'b1);
        rd = prdata; err = pslverr; push = tx_wr_en; pb = tx_wdata;
        if (rxd) begin
            rx_valid = 1'b1; rx_data = rxb; rx_parity_err = 1'b0; rx_frame_err = 1'b0;
        end
        @(posedge clk); #1;
        rx_valid = 1'b0; psel = 1'b0; penable = 1'b0;
        chk("pready_after", pready, 1'b0);
        chk("push_after", tx_wr_en, 1'b0);
        chk("prdata_after", prdata, 32'h0);
        @(posedge clk); #1;
    endtask

    task automatic do_write(input logic [1:0] rs, input logic [31:0] wd, input logic full);
        logic [31:0] rd; logic err, push; logic [7:0] pb;
        apb(1'b1, rs, wd, full, 1'b0, 8'h00, rd, err, push, pb);
        chk("wr_pslverr", err, (rs == 2'd0) && full);
        chk("wr_push", push, (rs == 2'd0) && !full);
        if (rs == 2'd0 && !full) chk("wr_tx_wdata", pb, wd[7:0]);
        case (rs)
            2'd1: m_lcr = wd[7:0];
            2'd2: begin
                if (wd[2]) m_ovr = 1'b0;
                if (wd[3]) m_pe = 1'b0;
                if (wd[4]) m_fe = 1'b0;
            end
            2'd3: m_ier = wd[1:0];
            default: ;
        endcase
        chk("irq_after_wr", irq, m_irq());
        chk_lcr_pins();
    endtask

    task automatic do_read(input logic [1:0] rs, input logic full,
                           input logic rxd, input logic [7:0] rxb, output logic [31:0] rd);
        logic [31:0] exp; logic err, push; logic [7:0] pb;
        case (rs)
            2'd0: exp = {24'h0, m_hold};
            2'd1: exp = {24'h0, m_lcr};
            2'd2: exp = {27'h0, m_fe, m_pe, m_ovr, full, m_avail};
            default: exp = {30'h0, m_ier};
        endcase
        apb(1'b0, rs, $urandom, full, rxd, rxb, rd, err, push, pb);
        chk("rd_prdata", rd, exp);
        chk("rd_pslverr", err, 1'b0);
        chk("rd_push", push, 1'b0);
        if (rs == 2'd0) m_avail = 1'b0;
        if (rxd) model_rx(rxb, 1'b0, 1'b0);
        chk("irq_after_rd", irq, m_irq());
    endtask

    task automatic rx_push(input logic [7:0] b, input logic p, input logic f);
        rx_valid = 1'b1; rx_data = b; rx_parity_err = p; rx_frame_err = f;
        @(posedge clk); #1;
        rx_valid = 1'b0; rx_parity_err = 1'b0; rx_frame_err = 1'b0;
        @(posedge clk); #1;
        model_rx(b, p, f);
        chk("irq_after_rx", irq, m_irq());
    endtask

    initial begin
        logic [31:0] rd;
        int op;
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 4'h0;
        pwdata = 32'h0; tx_full = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        rx_parity_err = 1'b0; rx_frame_err = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1; rst = 1'b0;

        // Reset state
        chk("rst_pready", pready, 1'b0);
        chk("rst_prdata", prdata, 32'h0);
        chk("rst_pslverr", pslverr, 1'b0);
        chk("rst_tx_wr_en", tx_wr_en, 1'b0);
        chk("rst_tx_wdata", tx_wdata, 8'h00);
        chk("rst_irq", irq, 1'b0);
        chk_lcr_pins();
        do_read(2'd1, 1'b0, 1'b0, 8'h00, rd);
        chk("rst_lcr_06", rd, 32'h06);
        do_read(2'd2, 1'b0, 1'b0, 8'h00, rd);
        chk("rst_status_0", rd, 32'h0);
        do_read(2'd3, 1'b0, 1'b0, 8'h00, rd);
        chk("rst_ier_0", rd, 32'h0);

        // TX push and full rejection
        do_write(2'd0, 32'h0000_00A5, 1'b0);
        do_write(2'd0, 32'h0000_005A, 1'b1);

        // Overrun scenario
        rx_push(8'h3C, 1'b0, 1'b0);
        rx_push(8'h7E, 1'b0, 1'b0);
        do_read(2'd2, 1'b0, 1'b0, 8'h00, rd);
        chk("ovr_status_05", rd, 32'h05);
        do_read(2'd0, 1'b0, 1'b0, 8'h00, rd);
        chk("ovr_data_3c", rd, 32'h3C);
        do_write(2'd2, 32'h04, 1'b0);
        do_read(2'd2, 1'b0, 1'b0, 8'h00, rd);
        chk("ovr_cleared", rd, 32'h00);

        // Error interrupt
        do_write(2'd3, 32'h2, 1'b0);
        rx_push(8'h55, 1'b1, 1'b0);
        chk("irq_parity_set", irq, 1'b1);
        do_read(2'd0, 1'b0, 1'b0, 8'h00, rd);
        chk("irq_still_set", irq, 1'b1);
        do_write(2'd2, 32'h08, 1'b0);
        chk("irq_cleared", irq, 1'b0);

        // rx_valid coincident with DATA-read DONE
        rx_push(8'h11, 1'b0, 1'b0);
        do_read(2'd0, 1'b0, 1'b1, 8'h22, rd);
        chk("coinc_old_byte", rd, 32'h11);
        do_read(2'd2, 1'b0, 1'b0, 8'h00, rd);
        chk("coinc_status", rd, 32'h01);
        do_read(2'd0, 1'b0, 1'b0, 8'h00, rd);
        chk("coinc_new_byte", rd, 32'h22);

        // LCR decode onto pins
        do_write(2'd1, 32'h1B, 1'b0);
        chk("lcr_tlen_01", tlen, 2'b01);
        chk("lcr_bclk_1", bclk_mode, 1'b1);
        chk("lcr_pen_1", parity_en, 1'b1);
        chk("lcr_ptype_1", parity_type, 1'b1);

        // Randomized traffic against the model
        for (int i = 0; i < 80; i++) begin
            op = int'($urandom_range(8));
            case (op)
                0: do_write(2'd1, $urandom, 1'b0);
                1: do_write(2'd3, $urandom, 1'b0);
                2: do_write(2'd2, $urandom, 1'b0);
                3: do_write(2'd0, $urandom, 1'($urandom));
                4: rx_push(8'($urandom), $urandom_range(3) == 0, $urandom_range(3) == 0);
                5: do_read(2'd0, 1'b0, 1'($urandom_range(3) == 0), 8'($urandom), rd);
                6: do_read(2'd2, 1'($urandom), 1'b0, 8'h00, rd);
                7: do_read(2'd1, 1'b0, 1'b0, 8'h00, rd);
                default: do_read(2'd3, 1'b0, 1'b0, 8'h00, rd);
            endcase
        end

        // Reset in the middle of an LCR write
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'h4; pwdata = 32'hFF;
        @(posedge clk); #1;
        penable = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_pready_a", pready, 1'b0);
        @(posedge clk); #1;
        chk("midrst_pready_b", pready, 1'b0);
        rst = 1'b0; psel = 1'b0; penable = 1'b0;
        model_reset();
        @(posedge clk); #1;
        chk("midrst_irq", irq, 1'b0);
        do_read(2'd1, 1'b0, 1'b0, 8'h00, rd);
        chk("midrst_lcr_06", rd, 32'h06);
        do_read(2'd2, 1'b0, 1'b0, 8'h00, rd);
        chk("midrst_status_0", rd, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
